// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock (shift/subtract).
// Optional macro DIV_BYZERO_ERR_EN: divide-by-zero short-cut with error flag.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    // Partial remainder always stays below the divisor, so WIDTH bits hold it;
    // the shifted value needs one extra bit before the compare.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] r_sub;
    logic             ge;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             accept;

    // One restoring step: shift in next dividend bit, trial-subtract divisor
    always_comb begin
        r_sh  = {r_q, q_q[WIDTH-1]};
        ge    = (r_sh >= {1'b0, dvs_q});
        r_sub = r_sh[WIDTH-1:0] - dvs_q;
        r_nxt = ge ? r_sub : r_sh[WIDTH-1:0];
        q_nxt = (q_q << 1) | WIDTH'(ge);
    end

    // Next-state and output-register logic for the IDLE/RUN/DONE controller
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        accept  = start && (state_q != RUN);

        if (state_q == RUN) begin
            r_d     = r_nxt;
            q_d     = q_nxt;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                state_d = DONE;
                done_d  = 1'b1;
                quot_d  = q_nxt;
                rem_d   = r_nxt;
                dbz_d   = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else if (accept) begin
            dvs_d   = divisor;
            q_d     = dividend;
            r_d     = '0;
            count_d = CW'(WIDTH);
            state_d = RUN;
            busy_d  = 1'b1;
`ifdef DIV_BYZERO_ERR_EN
            if (divisor == '0) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                quot_d  = '1;
                rem_d   = dividend;
                dbz_d   = 1'b1;
            end
`endif
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and registered outputs; reset aborts any division in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive bench for seq_restoring_divider (WIDTH=4),
// scoreboard of expected results popped on each done pulse.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = W'(a);
`ifdef DIV_BYZERO_ERR_EN
            e.dbz = 1'b1;
            e.cyc = 0;
`else
            e.dbz = 1'b0;
            e.cyc = W;
`endif
        end else begin
            e.q   = W'(a / b);
            e.r   = W'(a % b);
            e.dbz = 1'b0;
            e.cyc = W;
        end
        sb.push_back(e);
    endtask

    // Drive a start request for one edge; leaves start high for the caller
    task automatic issue(input int a, input int b, input bit track);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        if (track) push(a, b);
        step();
    endtask

    // Count busy cycles, check outputs hold, then check the done cycle
    task automatic finish_op(input int skip);
        exp_t         e;
        logic [W-1:0] hq;
        logic [W-1:0] hr;
        int           cnt;
        hq  = quotient;
        hr  = remainder;
        cnt = skip;
        while (busy === 1'b1 && cnt < 40) begin
            chk("hold_q", quotient, hq);
            chk("hold_r", remainder, hr);
            cnt++;
            step();
        end
        chk("done", done, 1);
        chk("busy_low", busy, 0);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("busy_cycles", cnt, e.cyc);
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", div_by_zero, e.dbz);
        end
    endtask

    task automatic single(input int a, input int b);
        issue(a, b, 1'b1);
        start = 1'b0;
        finish_op(0);
        step();
        chk("done_pulse", done, 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        step();

        single(13, 3);
        single(15, 1);
        single(5, 7);
        single(0, 9);
        single(9, 0);
        single(8, 2);

        // start pulsed during RUN is ignored
        issue(13, 3, 1'b1);
        start = 1'b0;
        chk("ign_busy0", busy, 1);
        step();
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        step();
        start = 1'b0;
        finish_op(2);
        step();

        // start held across two operations
        issue(13, 3, 1'b1);
        finish_op(0);
        issue(14, 4, 1'b1);
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done", done, 0);
        finish_op(0);
        step();

        // reset during iteration 2 aborts
        issue(11, 2, 1'b0);
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_done", done, 0);
        end
        single(11, 2);

        // exhaustive sweep, back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                issue(a, b, 1'b1);
                chk("sweep_busy", busy, 1);
                finish_op(0);
            end
        end
        start = 1'b0;
        step();
        chk("sweep_idle", done, 0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
